// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared sizes, FSM states and helpers for the 8-way request arbiter
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// rtl/prio_enc8.sv - combinational 8-to-3 priority encoder, highest set index wins
module prio_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] din,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    // Ascending scan so the last hit, i.e. the highest index, is what remains.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (din[i]) begin
                idx = ID_W'(i);
            end
        end
        valid = |din;
    end

endmodule

// File: rtl/req_arbiter8.sv
// rtl/req_arbiter8.sv - 8-requester arbiter with round-robin or fixed priority and hold-time limit
module req_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int RR_EN    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    arb_state_t         state, state_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [ID_W-1:0]    gnt_id_d;
    logic               gnt_valid_d;
    logic               timeout_d;
    logic [ID_W-1:0]    last_id, last_id_d;
    logic [7:0]         hold_cnt, hold_cnt_d;

    logic [ID_W-1:0]    rot_amt;
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W-1:0]    enc_idx;
    logic               enc_valid;
    logic [ID_W-1:0]    win_id;

    // Rotating by last_id puts requester last_id-1 at bit 7, so the
    // highest-wins encoder walks last_id-1, last_id-2, ... down to last_id.
    assign rot_amt = (RR_EN != 0) ? last_id : '0;
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[rot_amt +: N_REQ];

    prio_enc8 u_prio_enc8 (
        .din   (req_rot),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign win_id = enc_idx + rot_amt;

    always_comb begin
        state_d     = state;
        gnt_d       = gnt;
        gnt_id_d    = gnt_id;
        gnt_valid_d = gnt_valid;
        timeout_d   = 1'b0;
        last_id_d   = last_id;
        hold_cnt_d  = hold_cnt;

        case (state)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_d     = ST_GRANT;
                    gnt_d       = id2onehot(win_id);
                    gnt_id_d    = win_id;
                    gnt_valid_d = 1'b1;
                    last_id_d   = win_id;
                    hold_cnt_d  = '0;
                end
            end
            ST_GRANT: begin
                // A drop takes precedence over expiry, so no timeout on a voluntary release.
                if (!req[gnt_id]) begin
                    state_d     = ST_RELEASE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_d     = ST_RELEASE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                end else begin
                    hold_cnt_d  = hold_cnt + 8'd1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            last_id   <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_d;
            gnt       <= gnt_d;
            gnt_id    <= gnt_id_d;
            gnt_valid <= gnt_valid_d;
            timeout   <= timeout_d;
            last_id   <= last_id_d;
            hold_cnt  <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_req_arbiter8.sv
// tb/tb_req_arbiter8.sv - bench for req_arbiter8 in round-robin and fixed-priority builds
module tb_req_arbiter8;

    localparam int HOLD = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;

    logic [7:0] gnt_rr, gnt_fp;
    logic [2:0] id_rr, id_fp;
    logic       v_rr, v_fp;
    logic       to_rr, to_fp;

    int checks = 0;
    int errors = 0;

    // Reference model per build (0 = round robin, 1 = fixed): owner of the
    // current tenure (-1 none), cycles it has been visible, cooldown edges.
    int owner [2];
    int held  [2];
    int cool  [2];
    int last  [2];
    bit tmo   [2];

    req_arbiter8 #(.HOLD_MAX(HOLD), .RR_EN(1)) dut_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt_rr),
        .gnt_id    (id_rr),
        .gnt_valid (v_rr),
        .timeout   (to_rr)
    );

    req_arbiter8 #(.HOLD_MAX(HOLD), .RR_EN(0)) dut_fp (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt_fp),
        .gnt_id    (id_fp),
        .gnt_valid (v_fp),
        .timeout   (to_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %02h expected %02h", tag, obs, expv);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input bit rr, input int lst);
        for (int k = 1; k <= 8; k++) begin
            int id;
            id = rr ? ((lst - k + 16) % 8) : (8 - k);
            if (r[id]) return id;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            owner[m] = -1;
            held[m]  = 0;
            cool[m]  = 0;
            last[m]  = 0;
            tmo[m]   = 1'b0;
        end
    endtask

    task automatic model_step(input logic [7:0] r);
        for (int m = 0; m < 2; m++) begin
            tmo[m] = 1'b0;
            if (owner[m] >= 0) begin
                if (!r[owner[m]]) begin
                    owner[m] = -1;
                    cool[m]  = 1;
                end else if (held[m] == HOLD) begin
                    owner[m] = -1;
                    cool[m]  = 1;
                    tmo[m]   = 1'b1;
                end else begin
                    held[m]++;
                end
            end else if (cool[m] > 0) begin
                cool[m]--;
            end else if (r != 8'h00) begin
                owner[m] = pick(r, m == 0, last[m]);
                last[m]  = owner[m];
                held[m]  = 1;
            end
        end
    endtask

    task automatic compare(input int m, input logic [7:0] g, input logic [2:0] id,
                           input logic v, input logic t);
        logic [7:0] eg;
        string      nm;
        nm = (m == 0) ? "rr" : "fp";
        eg = (owner[m] >= 0) ? (8'h01 << owner[m]) : 8'h00;
        chk({nm, "_gnt"}, g, eg);
        chk({nm, "_valid"}, {7'b0, v}, {7'b0, owner[m] >= 0});
        chk({nm, "_timeout"}, {7'b0, t}, {7'b0, tmo[m]});
        if (owner[m] >= 0) begin
            chk({nm, "_gnt_id"}, {5'b0, id}, 8'(owner[m]));
        end
    endtask

    task automatic cyc(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        compare(0, gnt_rr, id_rr, v_rr, to_rr);
        compare(1, gnt_fp, id_fp, v_fp, to_fp);
    endtask

    initial begin
        logic [7:0] r;
        int         len;

        rst_n = 1'b0;
        req   = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        compare(0, gnt_rr, id_rr, v_rr, to_rr);
        compare(1, gnt_fp, id_fp, v_fp, to_fp);
        chk("reset_id_rr", {5'b0, id_rr}, 8'h00);
        rst_n = 1'b1;

        // First grant after reset searches 7..0
        cyc(8'h81);
        chk("first_gnt", gnt_rr, 8'h80);
        chk("first_id", {5'b0, id_rr}, 8'h07);
        repeat (3) cyc(8'h00);

        // Drop after 5 granted cycles: clean release, no timeout
        repeat (5) cyc(8'h08);
        chk("drop5_gnt_before", gnt_rr, 8'h08);
        cyc(8'h00);
        chk("drop5_gnt", gnt_rr, 8'h00);
        chk("drop5_timeout", {7'b0, to_rr}, 8'h00);
        repeat (2) cyc(8'h00);

        // Drop in the very cycle expiry would have fired
        repeat (HOLD) cyc(8'h08);
        cyc(8'h00);
        chk("drop_at_expiry_timeout", {7'b0, to_fp}, 8'h00);
        chk("drop_at_expiry_gnt", gnt_fp, 8'h00);
        repeat (2) cyc(8'h00);

        // All requesting: fixed build revokes id 7 after HOLD cycles with a pulse
        repeat (HOLD) cyc(8'hFF);
        chk("fp_full_hold_gnt", gnt_fp, 8'h80);
        cyc(8'hFF);
        chk("fp_expiry_timeout", {7'b0, to_fp}, 8'h01);
        chk("fp_expiry_gnt", gnt_fp, 8'h00);
        repeat (300) cyc(8'hFF);

        // Random held patterns with occasional flips of arbitrary bits
        for (int s = 0; s < 80; s++) begin
            r   = 8'($urandom);
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) r = r ^ (8'h01 << $urandom_range(0, 7));
                cyc(r);
            end
        end

        // Asynchronous reset in the middle of a grant
        repeat (3) cyc(8'h00);
        repeat (4) cyc(8'h24);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_gnt_rr", gnt_rr, 8'h00);
        chk("async_rst_gnt_fp", gnt_fp, 8'h00);
        chk("async_rst_timeout", {7'b0, to_rr}, 8'h00);
        @(negedge clk);
        compare(0, gnt_rr, id_rr, v_rr, to_rr);
        compare(1, gnt_fp, id_fp, v_fp, to_fp);
        rst_n = 1'b1;
        cyc(8'hFF);
        chk("post_rst_gnt", gnt_rr, 8'h80);
        repeat (60) cyc(8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
